// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the line-fill/write-back engine state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW,
    W,
    B,
    DONE
  } axi_master_state_t;

endpackage

// File: rtl/dcache_axi_master.sv
// Data-cache line engine: turns one refill or write-back request into a single
// fixed-length 32-bit INCR burst on AXI4, one request in flight at a time.
module dcache_axi_master
  import axi_pkg::*;
#(
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_write,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [LINE_WORDS*32-1:0]      req_wdata,
  output logic                          fill_valid,
  output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
  output logic [31:0]                   fill_data,
  output logic                          done,
  output logic                          done_err,
  output logic                          axi_arid,
  output logic [31:0]                   axi_araddr,
  output logic [7:0]                    axi_arlen,
  output logic [2:0]                    axi_arsize,
  output logic [1:0]                    axi_arburst,
  output logic                          axi_arvalid,
  input  logic                          axi_arready,
  input  logic                          axi_rid,
  input  logic [31:0]                   axi_rdata,
  input  logic [1:0]                    axi_rresp,
  input  logic                          axi_rlast,
  input  logic                          axi_rvalid,
  output logic                          axi_rready,
  output logic                          axi_awid,
  output logic [31:0]                   axi_awaddr,
  output logic [7:0]                    axi_awlen,
  output logic [2:0]                    axi_awsize,
  output logic [1:0]                    axi_awburst,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  output logic [31:0]                   axi_wdata,
  output logic [3:0]                    axi_wstrb,
  output logic                          axi_wlast,
  output logic                          axi_wvalid,
  input  logic                          axi_wready,
  input  logic                          axi_bid,
  input  logic [1:0]                    axi_bresp,
  input  logic                          axi_bvalid,
  output logic                          axi_bready
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  axi_master_state_t state, state_next;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [LINE_WORDS*32-1:0] line_q;
  logic [IDX_W-1:0]         cnt;
  logic                     err_q;

  // Burst length comes from the beat counter, so rlast and the IDs are not needed.
  logic unused_axi;
  assign unused_axi = ^{axi_rid, axi_rlast, axi_bid};

  assign axi_arid    = 1'b0;
  assign axi_araddr  = 32'(addr_q);
  assign axi_arlen   = 8'(LINE_WORDS - 1);
  assign axi_arsize  = AXI_SIZE_4B;
  assign axi_arburst = AXI_BURST_INCR;
  assign axi_awid    = 1'b0;
  assign axi_awaddr  = 32'(addr_q);
  assign axi_awlen   = 8'(LINE_WORDS - 1);
  assign axi_awsize  = AXI_SIZE_4B;
  assign axi_awburst = AXI_BURST_INCR;
  assign axi_wstrb   = 4'hF;
  assign axi_wdata   = line_q[32*int'(cnt) +: 32];
  assign fill_idx    = cnt;
  assign fill_data   = axi_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr_q <= '0;
      line_q <= '0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          cnt   <= '0;
          err_q <= 1'b0;
          if (req_valid) begin
            addr_q <= req_addr & ~OFF_MASK;
            line_q <= req_wdata;
          end
        end
        R: if (axi_rvalid) begin
          cnt <= cnt + IDX_W'(1);
          if (axi_rresp != AXI_RESP_OKAY) err_q <= 1'b1;
        end
        W: if (axi_wready) cnt <= cnt + IDX_W'(1);
        B: if (axi_bvalid && axi_bresp != AXI_RESP_OKAY) err_q <= 1'b1;
        default: ;
      endcase
    end
  end

  // The counter wraps to zero on the last beat, ready for the next request.
  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    axi_arvalid = 1'b0;
    axi_rready  = 1'b0;
    axi_awvalid = 1'b0;
    axi_wvalid  = 1'b0;
    axi_wlast   = 1'b0;
    axi_bready  = 1'b0;
    fill_valid  = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_write ? AW : AR;
      end
      AR: begin
        axi_arvalid = 1'b1;
        if (axi_arready) state_next = R;
      end
      R: begin
        axi_rready = 1'b1;
        fill_valid = axi_rvalid;
        if (axi_rvalid && cnt == LAST_IDX) state_next = DONE;
      end
      AW: begin
        axi_awvalid = 1'b1;
        if (axi_awready) state_next = W;
      end
      W: begin
        axi_wvalid = 1'b1;
        axi_wlast  = (cnt == LAST_IDX);
        if (axi_wready && cnt == LAST_IDX) state_next = B;
      end
      B: begin
        axi_bready = 1'b1;
        if (axi_bvalid) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        done_err   = err_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
